fetch_unit: RTL

Instruction-fetch stage that generates the program counter, drives the instruction memory address and delivers each fetched instruction with its PC and a valid flag to decode. It sits directly upstream of `imem`: `imem_addr` feeds `imem.a` and `imem.rd` returns on `imem_rd`. It compensates for the one-cycle registered read of the synthesised ROM, so back-to-back fetch has no bubble. It also handles decode stalls, branch redirects and misaligned-target faults.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, instruction-memory addressing and instruction delivery to decode.
// Latency: the first instruction is valid one edge after reset release; a redirect target is valid one edge after the redirect.
// Backpressure: while stall is high, instr, instr_pc and instr_valid are held. Redirect overrides stall.
//
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   stall                 - decode cannot accept the current instruction
//   redirect, redirect_pc - taken branch/jump and its byte target
//   imem_addr, imem_rd    - instruction memory address out, read data in
//   instr, instr_pc       - instruction and its byte address to decode
//   instr_valid           - instr/instr_pc are valid
//   fetch_fault           - misaligned redirect target; fetch is halted
//   fetch_count           - number of instructions accepted by decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          SYNC_IMEM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_next;
  logic        valid_q, valid_nxt;
  logic [31:0] count_q;
  logic        misaligned;

  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // pc_next is always the value pc_q loads on the coming edge. In
  // registered-read mode the ROM samples it on that same edge, so the word
  // for pc_q is on imem_rd exactly when pc_q updates.
  always_comb begin
    state_nxt = state;
    pc_next   = pc_q;
    valid_nxt = valid_q;
    case (state)
      BOOT: begin
        pc_next   = RESET_PC;
        valid_nxt = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        valid_nxt = 1'b1;
        if (redirect) begin
          if (misaligned) begin
            // Halt on the current PC; the bad target is never fetched.
            pc_next   = pc_q;
            valid_nxt = 1'b0;
            state_nxt = FAULT;
          end else begin
            pc_next = redirect_pc;
          end
        end else if (stall) begin
          pc_next = pc_q;
        end else begin
          pc_next = pc_q + 32'd4;
        end
      end
      FAULT: begin
        valid_nxt = 1'b0;
        if (redirect && !misaligned) begin
          pc_next   = redirect_pc;
          valid_nxt = 1'b1;
          state_nxt = RUN;
        end
      end
      default: begin
        pc_next   = RESET_PC;
        valid_nxt = 1'b0;
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_next;
      valid_q <= valid_nxt;
    end
  end

  // Instructions shown during a redirect cycle are wrong-path and not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (valid_q && !stall && !redirect) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign imem_addr   = SYNC_IMEM ? pc_next : pc_q;
  assign instr       = imem_rd;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;
  assign fetch_fault = (state == FAULT);
  assign fetch_count = count_q;

endmodule
